// File: rtl/sample_path_ctrl.sv
// sample_path_ctrl: input-path controller for the capture front end.
// Owns the sampler flags (demux, filter, group disable) and selects/masks
// the sample stream. Flag changes wait until no capture is running, and each
// applied change opens a settle window with out_valid held low.
//
// Ports:
//   clock, reset_n     : rising-edge clock, synchronous active-low reset
//   wr_flags           : one-cycle strobe, config_data holds a flags write
//   config_data        : [0] demux, [1] filter, [5:2] group 3..0 disable
//   capture_active     : capture armed/running, defers flag changes
//   raw_valid          : sample strobe for the current cycle
//   raw_data           : unfiltered samples
//   filtered_data      : noise-filter output
//   demux_data         : demux (double-rate) output
//   outdata            : selected, masked sample (registered)
//   out_valid          : outdata holds a valid sample
//   filter_en          : active filter enable
//   demux_en           : active demux enable
//   busy               : settle window in progress
//   pending            : a deferred flags write is waiting
module sample_path_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wr_flags,
    input  logic [31:0] config_data,
    input  logic        capture_active,
    input  logic        raw_valid,
    input  logic [31:0] raw_data,
    input  logic [31:0] filtered_data,
    input  logic [31:0] demux_data,
    output logic [31:0] outdata,
    output logic        out_valid,
    output logic        filter_en,
    output logic        demux_en,
    output logic        busy,
    output logic        pending
);

    typedef enum logic {
        S_RUN,
        S_SETTLE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    // A zero-length settle window means an apply lands straight in RUN.
    localparam state_e ST_APPLY = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       flags_q, flags_d;
    logic [5:0]       pflags_q, pflags_d;
    logic             pend_q, pend_d;
    logic [31:0]      outdata_q, outdata_d;
    logic             out_valid_q, out_valid_d;

    logic             apply;
    logic [31:0]      sel;
    logic [31:0]      mask;

    logic unused_cfg;
    assign unused_cfg = ^config_data[31:6];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_APPLY;
            cnt_q       <= CNT_LOAD;
            flags_q     <= '0;
            pflags_q    <= '0;
            pend_q      <= 1'b0;
            outdata_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            pflags_q    <= pflags_d;
            pend_q      <= pend_d;
            outdata_q   <= outdata_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        pflags_d = pflags_q;
        pend_d   = pend_q;
        apply    = pend_q & ~capture_active;

        if (apply) begin
            flags_d = pflags_q;
            pend_d  = 1'b0;
            state_d = ST_APPLY;
            cnt_d   = CNT_LOAD;
        end else if (state_q == S_SETTLE) begin
            if (cnt_q <= 1) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // A write in the apply cycle re-arms pending for one more apply.
        if (wr_flags) begin
            pend_d   = 1'b1;
            pflags_d = config_data[5:0];
        end
    end

    always_comb begin
        if (flags_q[0]) begin
            sel = demux_data;
        end else if (flags_q[1]) begin
            sel = filtered_data;
        end else begin
            sel = raw_data;
        end

        mask = {{8{flags_q[5]}}, {8{flags_q[4]}},
                {8{flags_q[3]}}, {8{flags_q[2]}}};

        outdata_d = sel & ~mask;
        // The sample taken on an apply edge uses the old mode, so drop it.
        out_valid_d = (state_q == S_RUN) && !apply && raw_valid;
    end

    assign outdata   = outdata_q;
    assign out_valid = out_valid_q;
    assign demux_en  = flags_q[0];
    assign filter_en = flags_q[1];
    assign busy      = (state_q == S_SETTLE);
    assign pending   = pend_q;

endmodule

// File: tb/tb_sample_path_ctrl.sv
// tb_sample_path_ctrl: directed self-checking bench for sample_path_ctrl.
// Linear sequence of steps with hand-computed expectations.
module tb_sample_path_ctrl;

    logic        clock;
    logic        reset_n;
    logic        wr_flags;
    logic [31:0] config_data;
    logic        capture_active;
    logic        raw_valid;
    logic [31:0] raw_data;
    logic [31:0] filtered_data;
    logic [31:0] demux_data;
    logic [31:0] outdata;
    logic        out_valid;
    logic        filter_en;
    logic        demux_en;
    logic        busy;
    logic        pending;

    int n_cmp = 0;
    int n_err = 0;

    sample_path_ctrl #(
        .SETTLE_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .wr_flags(wr_flags),
        .config_data(config_data),
        .capture_active(capture_active),
        .raw_valid(raw_valid),
        .raw_data(raw_data),
        .filtered_data(filtered_data),
        .demux_data(demux_data),
        .outdata(outdata),
        .out_valid(out_valid),
        .filter_en(filter_en),
        .demux_en(demux_en),
        .busy(busy),
        .pending(pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after the apply edge (counter = 4, already checked).
    task automatic wait_settle(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_vld_lo"}, 32'(out_valid), 32'd0);
        end
        tick();
        chk({tag, "_run"}, 32'(busy), 32'd0);
        chk({tag, "_vld_first"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, outdata, exp);
    endtask

    task automatic post_reset_seq(input string tag);
        raw_valid = 1'b1;
        raw_data  = 32'hA5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_vld_lo"}, 32'(out_valid), 32'd0);
            tick();
        end
        chk({tag, "_run"}, 32'(busy), 32'd0);
        chk({tag, "_vld_first"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, outdata, 32'hA5A5_A5A5);
        raw_data = 32'h5A5A_5A5A;
        tick();
        chk({tag, "_data2"}, outdata, 32'h5A5A_5A5A);
    endtask

    task automatic write_flags(input logic [31:0] v);
        wr_flags    = 1'b1;
        config_data = v;
        tick();
        wr_flags    = 1'b0;
        config_data = 32'h0;
    endtask

    initial begin
        reset_n        = 1'b0;
        wr_flags       = 1'b0;
        config_data    = 32'h0;
        capture_active = 1'b0;
        raw_valid      = 1'b0;
        raw_data       = 32'h0;
        filtered_data  = 32'h1234_5678;
        demux_data     = 32'hCAFE_BABE;
        tick();
        tick();
        chk("rst_outdata", outdata, 32'h0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_filt", 32'(filter_en), 32'd0);
        chk("rst_dmx", 32'(demux_en), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        reset_n = 1'b1;
        post_reset_seq("boot");

        // Filter mode
        write_flags(32'h2);
        chk("f_pend", 32'(pending), 32'd1);
        chk("f_nofilt", 32'(filter_en), 32'd0);
        chk("f_nobusy", 32'(busy), 32'd0);
        tick();
        chk("f_pend_clr", 32'(pending), 32'd0);
        chk("f_filt", 32'(filter_en), 32'd1);
        chk("f_busy", 32'(busy), 32'd1);
        chk("f_vld_lo", 32'(out_valid), 32'd0);
        wait_settle("f", 32'h1234_5678);

        // Demux + filter, demux wins
        write_flags(32'h3);
        tick();
        chk("d_dmx", 32'(demux_en), 32'd1);
        chk("d_filt", 32'(filter_en), 32'd1);
        wait_settle("d", 32'hCAFE_BABE);

        // Groups 0 and 2 disabled
        raw_data = 32'hFFFF_FFFF;
        write_flags(32'h14);
        tick();
        chk("m_dmx", 32'(demux_en), 32'd0);
        chk("m_filt", 32'(filter_en), 32'd0);
        wait_settle("m", 32'hFF00_FF00);

        // Deferred while capture is active; last write wins
        capture_active = 1'b1;
        write_flags(32'h2);
        write_flags(32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("c_pend", 32'(pending), 32'd1);
            chk("c_filt", 32'(filter_en), 32'd0);
            chk("c_dmx", 32'(demux_en), 32'd0);
            chk("c_busy", 32'(busy), 32'd0);
            tick();
        end
        capture_active = 1'b0;
        tick();
        chk("c_dmx_on", 32'(demux_en), 32'd1);
        chk("c_filt_off", 32'(filter_en), 32'd0);
        chk("c_pend_clr", 32'(pending), 32'd0);
        chk("c_busy_on", 32'(busy), 32'd1);
        wait_settle("c", 32'hCAFE_BABE);
        tick();
        chk("c_single", 32'(busy), 32'd0);

        // Write during settle restarts the window
        write_flags(32'h2);
        tick();
        chk("r_filt", 32'(filter_en), 32'd1);
        tick();
        tick();
        write_flags(32'h0);
        chk("r_pend", 32'(pending), 32'd1);
        chk("r_busy", 32'(busy), 32'd1);
        chk("r_filt_hold", 32'(filter_en), 32'd1);
        tick();
        chk("r_filt_off", 32'(filter_en), 32'd0);
        chk("r_pend_clr", 32'(pending), 32'd0);
        chk("r_busy2", 32'(busy), 32'd1);
        wait_settle("r", 32'hFFFF_FFFF);

        // Reset mid-settle discards everything
        write_flags(32'h3);
        tick();
        tick();
        reset_n     = 1'b0;
        wr_flags    = 1'b1;
        config_data = 32'h3;
        tick();
        wr_flags    = 1'b0;
        config_data = 32'h0;
        chk("x_outdata", outdata, 32'h0);
        chk("x_vld", 32'(out_valid), 32'd0);
        chk("x_filt", 32'(filter_en), 32'd0);
        chk("x_dmx", 32'(demux_en), 32'd0);
        chk("x_pend", 32'(pending), 32'd0);
        reset_n = 1'b1;
        post_reset_seq("x");
        tick();
        chk("x_pend_after", 32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_path_ctrl.md
Name: sample_path_ctrl

Overview:
- Input-path controller for the capture front end. Owns the sampler flags: demux enable, noise-filter enable and channel-group disable.
- Selects raw, filtered or demux sample data and masks disabled groups. Applies flag changes only while no capture is running.
- After a mode change or reset, suppresses output valid for a settle window so stale filter and demux pipeline contents never reach the trigger or storage logic.

Parameters:
- SETTLE_CYCLES, 4, clock cycles out_valid stays low after a mode change is applied (covers filter and demux pipeline depth); 0 is legal.
- CNT_W, 4, settle counter width; must hold SETTLE_CYCLES.

Ports:
- clock  in  1  sample clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_flags  in  1  one-cycle strobe; config_data is a flags write.
- config_data  in  32  bit0 demux, bit1 filter, bits5:2 group disable (bit2 = group0, channels 7:0, ... bit5 = group3, channels 31:24); other bits ignored.
- capture_active  in  1  high while a capture is armed or running; flag changes are deferred while high.
- raw_valid  in  1  sample strobe for the current cycle.
- raw_data  in  32  unfiltered samples.
- filtered_data  in  32  noise-filter output.
- demux_data  in  32  demux (double-rate) output.
- outdata  out  32  selected, masked sample, registered.
- out_valid  out  1  outdata is a valid sample.
- filter_en  out  1  active filter enable, to the sampler.
- demux_en  out  1  active demux enable, to the sampler.
- busy  out  1  high in SETTLE state.
- pending  out  1  a deferred flags write is waiting.

Behaviour:
- Reset (reset_n low at a rising edge):
  - active flags = 0, pending = 0, pending flags = 0.
  - outdata = 0, out_valid = 0.
  - State = SETTLE with counter = SETTLE_CYCLES (RUN if SETTLE_CYCLES = 0).
  - Reset mid-settle or mid-pending discards everything.
- State machine has two states, RUN and SETTLE.
- Flags write (wr_flags high):
  - The pending register captures config_data[5:0] and pending is set, in every state.
  - Last write wins; an earlier pending write is overwritten.
- Apply condition: pending = 1 and capture_active = 0.
  - Any state: on the next edge the active flags load the pending flags, pending clears, state goes to SETTLE and the counter loads SETTLE_CYCLES.
  - The apply condition is evaluated on registered pending. A write while capture_active = 0 therefore applies on the edge after the write edge. There is 1 cycle of pending = 1.
  - A write arriving in the same cycle as an apply re-latches pending and applies one cycle later, restarting the settle window.
  - If capture_active rises in the same cycle pending is set, the change is deferred until capture_active falls.
- SETTLE state:
  - out_valid = 0 and busy = 1.
  - The counter decrements every clock regardless of raw_valid.
  - When the counter is 1 and no apply condition holds, next state is RUN. With SETTLE_CYCLES = 0, state goes straight to RUN on the apply edge.
- RUN state:
  - out_valid <= raw_valid, with 1-cycle latency.
  - outdata <= sel & ~mask on every edge, including when out_valid = 0.
- Data select and mask:
  - sel = demux_data if demux_en, else filtered_data if filter_en, else raw_data. Demux has priority when both flags are set.
  - mask = each disabled group's byte set to all ones; masked bits read 0.
- filter_en and demux_en reflect the active flags only. They never reflect the pending flags.
- Active flags never change while capture_active = 1.

Test Plan:
- Reset, then raw_valid = 1 with raw_data = 0xA5A5A5A5 and SETTLE_CYCLES = 4:
  - out_valid = 0 and busy = 1 for 4 cycles.
  - Then out_valid = 1 and outdata = 0xA5A5A5A5 one cycle after each input.
- Write config_data = 0x2 with capture_active = 0, filtered_data = 0x12345678:
  - pending = 1 for 1 cycle, then filter_en = 1 and busy = 1 for 4 cycles.
  - Then outdata = 0x12345678.
- Write 0x3 (demux + filter):
  - demux_en = 1 and filter_en = 1.
  - outdata tracks demux_data = 0xCAFEBABE, not filtered_data.
- Write 0x14 (groups 0 and 2 disabled), raw_data = 0xFFFFFFFF:
  - after settle, outdata = 0xFF00FF00.
- capture_active = 1, write 0x2, then 0x1:
  - flags unchanged and pending = 1 while active.
  - When capture_active falls, demux_en = 1, filter_en = 0, and a single settle window follows.
- Write 0x2, then 0x0 at settle cycle 2:
  - the settle window restarts and filter_en returns to 0.
  - reset_n low mid-settle clears everything and reproduces the post-reset sequence.
